// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core.
// Opcodes, FSM state encoding and instruction-word field helpers.
package acc_cpu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
  localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
  localparam logic [OPC_W-1:0] OP_AND = 3'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
  localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
  localparam logic [OPC_W-1:0] OP_STO = 3'd6;
  localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH_HI = 3'd0,
    S_FETCH_LO = 3'd1,
    S_EXEC     = 3'd2,
    S_OPRD     = 3'd3,
    S_OPWR     = 3'd4,
    S_HALTED   = 3'd5
  } state_t;

  // Opcode sits in the top three bits of the iw-bit instruction word.
  function automatic logic [OPC_W-1:0] ir_opcode(
    input logic [63:0] word,
    input int          iw
  );
    return OPC_W'(word >> (iw - OPC_W));
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Accumulator ALU: ADD/AND/XOR combine with acc, LDA passes data.
// Purely combinational; other opcodes return acc unchanged.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = acc;
    unique case (1'b1)
      (opcode == OP_ADD): result = acc + data;
      (opcode == OP_AND): result = acc & data;
      (opcode == OP_XOR): result = acc ^ data;
      (opcode == OP_LDA): result = data;
      default:            result = acc;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multicycle accumulator CPU: two-beat fetch, exec, operand access.
// Memory handshake via mem_ready; HALTED is left through resume.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              resume,
  output logic              halt,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int IW = 2 * DATA_W;

  if (ADDR_W != IW - OPC_W) begin : g_width_chk
    $fatal(1, "acc_cpu_core: ADDR_W must equal 2*DATA_W-3");
  end

  state_t state, state_n;

  logic [ADDR_W-1:0] pc, pc_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic [DATA_W-1:0] ir_hi, ir_hi_n;
  logic [DATA_W-1:0] ir_lo, ir_lo_n;

  logic [IW-1:0]     ir;
  logic [OPC_W-1:0]  op;
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W-1:0] alu_res;
  logic              acc_zero;

  logic              rd_req;
  logic              wr_req;
  logic [ADDR_W-1:0] addr_sel;

  assign ir       = {ir_hi, ir_lo};
  assign op       = ir_opcode(64'(ir), IW);
  assign ir_addr  = ADDR_W'(ir);
  assign acc_zero = (acc == '0);

  acc_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode (op),
    .acc    (acc),
    .data   (mem_rdata),
    .result (alu_res)
  );

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    acc_n    = acc;
    ir_hi_n  = ir_hi;
    ir_lo_n  = ir_lo;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    addr_sel = pc;
    unique case (state)
      S_FETCH_HI: begin
        rd_req = 1'b1;
        if (mem_ready) begin
          ir_hi_n = mem_rdata;
          pc_n    = pc + ADDR_W'(1);
          state_n = S_FETCH_LO;
        end
      end
      S_FETCH_LO: begin
        rd_req = 1'b1;
        if (mem_ready) begin
          ir_lo_n = mem_rdata;
          pc_n    = pc + ADDR_W'(1);
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        state_n = S_FETCH_HI;
        unique case (1'b1)
          (op == OP_HLT): state_n = S_HALTED;
          (op == OP_SKZ): begin
            if (acc_zero) pc_n = pc + ADDR_W'(2);
          end
          (op == OP_JMP): pc_n = ir_addr;
          (op == OP_STO): state_n = S_OPWR;
          default:        state_n = S_OPRD;
        endcase
      end
      S_OPRD: begin
        rd_req   = 1'b1;
        addr_sel = ir_addr;
        if (mem_ready) begin
          acc_n   = alu_res;
          state_n = S_FETCH_HI;
        end
      end
      S_OPWR: begin
        wr_req   = 1'b1;
        addr_sel = ir_addr;
        if (mem_ready) state_n = S_FETCH_HI;
      end
      S_HALTED: begin
        if (resume) state_n = S_FETCH_HI;
      end
      default: state_n = S_FETCH_HI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH_HI;
      pc    <= RESET_PC;
      acc   <= '0;
      ir_hi <= '0;
      ir_lo <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      acc   <= acc_n;
      ir_hi <= ir_hi_n;
      ir_lo <= ir_lo_n;
    end
  end

  // Gate with reset so requests drop at once on async assertion.
  assign mem_rd    = rd_req & reset;
  assign mem_wr    = wr_req & reset;
  assign halt      = (state == S_HALTED) & reset;
  assign mem_addr  = addr_sel;
  assign mem_wdata = acc;
  assign acc_out   = acc;
  assign pc_out    = pc;

endmodule
